// File: rtl/pov_load_scheduler.sv
// Once-per-frame vblank arbiter between the SPI vector buffer and the demo generator.
// Optional POV_HOLD_EN adds i_hold, which suppresses the grant for frames arbitrated while it is high.
//
//  state  | meaning
//  IDLE   | waiting for vsync_start
//  ARB    | one cycle: choose spi, demo or nothing
//  LOAD   | one cycle: load strobe (and spi ack) is live
//  SETTLE | POV regs settling, watch for vblank ending early
//  DONE   | frame handled, wait for vblank to end
module pov_load_scheduler #(
   parameter int SETTLE_CYCLES = 4,
   parameter int DEMO_DIV      = 1,
   parameter int FRAME_W       = 16,
   parameter int DROP_W        = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_vsync_start,
   input  logic               i_vblank,
   input  logic               i_spi_new,
   input  logic               i_demo_req,
`ifdef POV_HOLD_EN
   input  logic               i_hold,
`endif
   output logic               o_load_spi,
   output logic               o_load_demo,
   output logic               o_spi_ack,
   output logic [1:0]         o_grant,
   output logic               o_busy,
   output logic               o_late,
   output logic [FRAME_W-1:0] o_frame_count,
   output logic [DROP_W-1:0]  o_drop_count
);

   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int DIV_W = (DEMO_DIV > 1) ? $clog2(DEMO_DIV) : 1;

   typedef enum logic [2:0] {IDLE, ARB, LOAD, SETTLE, DONE} state_t;

   state_t             state;
   logic [CNT_W-1:0]   settle_cnt;
   logic [DIV_W-1:0]   div_cnt;
   logic               spi_pend;
   logic               last_demo;
   logic               demo_slot;
   logic               late_seen;
   logic               hold;
   logic               demo_ok;

`ifdef POV_HOLD_EN
   assign hold = i_hold;
`else
   assign hold = 1'b0;
`endif

   // Frame eligibility is captured at vsync, before div_cnt advances for this frame.
   assign demo_ok = i_demo_req && demo_slot;

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         settle_cnt    <= '0;
         div_cnt       <= '0;
         spi_pend      <= 1'b0;
         last_demo     <= 1'b1;
         demo_slot     <= 1'b0;
         late_seen     <= 1'b0;
         o_load_spi    <= 1'b0;
         o_load_demo   <= 1'b0;
         o_spi_ack     <= 1'b0;
         o_grant       <= 2'b00;
         o_busy        <= 1'b0;
         o_late        <= 1'b0;
         o_frame_count <= '0;
         o_drop_count  <= '0;
      end else begin
         o_load_spi  <= 1'b0;
         o_load_demo <= 1'b0;
         o_spi_ack   <= 1'b0;
         o_late      <= 1'b0;

         // A new frame landing on the ack cycle refills the buffer without a drop.
         if (i_spi_new) begin
            if (spi_pend && !o_spi_ack && (o_drop_count != {DROP_W{1'b1}}))
               o_drop_count <= o_drop_count + DROP_W'(1);
            spi_pend <= 1'b1;
         end else if (o_spi_ack) begin
            spi_pend <= 1'b0;
         end

         if (i_vsync_start) begin
            o_frame_count <= o_frame_count + FRAME_W'(1);
            div_cnt       <= (div_cnt == DIV_W'(DEMO_DIV - 1)) ? '0 : div_cnt + DIV_W'(1);
         end

         case (state)
            IDLE: begin
               if (i_vsync_start) begin
                  state     <= ARB;
                  demo_slot <= (div_cnt == '0);
                  late_seen <= 1'b0;
                  o_busy    <= 1'b1;
               end
            end
            ARB: begin
               if (hold) begin
                  state  <= DONE;
                  o_busy <= 1'b0;
               end else if (spi_pend && (!demo_ok || last_demo)) begin
                  state      <= LOAD;
                  o_load_spi <= 1'b1;
                  o_spi_ack  <= 1'b1;
                  o_grant    <= 2'b01;
                  last_demo  <= 1'b0;
               end else if (demo_ok) begin
                  state       <= LOAD;
                  o_load_demo <= 1'b1;
                  o_grant     <= 2'b10;
                  last_demo   <= 1'b1;
               end else begin
                  state  <= DONE;
                  o_busy <= 1'b0;
               end
            end
            LOAD: begin
               state      <= SETTLE;
               settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
            end
            SETTLE: begin
               if (!i_vblank && !late_seen) begin
                  o_late    <= 1'b1;
                  late_seen <= 1'b1;
               end
               if (settle_cnt == '0) begin
                  state  <= DONE;
                  o_busy <= 1'b0;
               end else begin
                  settle_cnt <= settle_cnt - CNT_W'(1);
               end
            end
            DONE: begin
               if (!i_vblank) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pov_load_scheduler.sv
// Randomized bench for pov_load_scheduler: a frame-level model predicts strobes, late pulses,
// busy, grant and counters; a negedge monitor checks DUT outputs against those predictions.
module tb_pov_load_scheduler;

   localparam int S   = 3;
   localparam int DIV = 2;
   localparam int FW  = 4;
   localparam int DW  = 3;
   localparam int BIG = 32'h7fff_ffff;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          i_vsync_start = 1'b0;
   logic          i_vblank = 1'b0;
   logic          i_spi_new = 1'b0;
   logic          i_demo_req = 1'b0;
   logic          o_load_spi, o_load_demo, o_spi_ack, o_busy, o_late;
   logic [1:0]    o_grant;
   logic [FW-1:0] o_frame_count;
   logic [DW-1:0] o_drop_count;

   pov_load_scheduler #(.SETTLE_CYCLES(S), .DEMO_DIV(DIV), .FRAME_W(FW), .DROP_W(DW)) dut (
      .clk(clk), .reset(reset), .i_vsync_start(i_vsync_start), .i_vblank(i_vblank),
      .i_spi_new(i_spi_new), .i_demo_req(i_demo_req), .o_load_spi(o_load_spi),
      .o_load_demo(o_load_demo), .o_spi_ack(o_spi_ack), .o_grant(o_grant), .o_busy(o_busy),
      .o_late(o_late), .o_frame_count(o_frame_count), .o_drop_count(o_drop_count));

   always #5 clk = ~clk;

   typedef struct {int cyc; logic [1:0] kind;} exp_t;
   exp_t sb_q[$];
   int   late_q[$];

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   bit   chk_en = 1'b0;

   // model state (frame-level view)
   bit         m_pend = 0, m_last_demo = 1, arb_elig = 0, late_done = 0;
   int         m_drops = 0, m_frames = 0, m_div = 0;
   logic [1:0] m_grant = 2'b00, load_kind = 2'b00;
   int         idle_from = 0, arb_at = -1, load_at = -1, done_at = -1;
   int         busy_lo = 1, busy_hi = 0, settle_lo = 1, settle_hi = 0;

   logic [1:0]    exp_grant = 2'b00;
   logic          exp_busy = 1'b0;
   logic [FW-1:0] exp_frames = '0;
   logic [DW-1:0] exp_drops = '0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, want);
      end
   endtask

   task automatic step(input logic rst, input logic vs, input logic vb, input logic sn, input logic dr);
      logic [1:0] kind;
      bit demo_ok, ack_now;
      @(posedge clk); #1;
      reset = rst; i_vsync_start = vs; i_vblank = vb; i_spi_new = sn; i_demo_req = dr;
      cyc++;
      // outputs visible during this cycle follow from earlier cycles only
      if (load_at == cyc) begin
         m_grant = load_kind;
         m_last_demo = (load_kind == 2'b10);
         sb_q.push_back('{cyc, load_kind});
      end
      exp_grant  = m_grant;
      exp_busy   = (cyc >= busy_lo && cyc <= busy_hi);
      exp_frames = FW'(m_frames);
      exp_drops  = DW'(m_drops);
      if (rst) begin
         m_pend = 0; m_last_demo = 1; m_drops = 0; m_frames = 0; m_div = 0; m_grant = 2'b00;
         idle_from = cyc + 1; arb_at = -1; load_at = -1; done_at = -1;
         busy_lo = 1; busy_hi = 0; settle_lo = 1; settle_hi = 0; late_done = 0;
      end else begin
         ack_now = (load_at == cyc && load_kind == 2'b01);
         if (arb_at == cyc) begin
            demo_ok = dr && arb_elig;
            if (m_pend && (!demo_ok || m_last_demo)) kind = 2'b01;
            else if (demo_ok)                        kind = 2'b10;
            else                                     kind = 2'b00;
            if (kind != 2'b00) begin
               load_at = cyc + 1; load_kind = kind; busy_hi = cyc + 1 + S;
               settle_lo = cyc + 2; settle_hi = cyc + 1 + S; done_at = cyc + 2 + S;
            end else begin
               busy_hi = cyc; done_at = cyc + 1;
            end
            arb_at = -1;
         end
         if (sn) begin
            if (m_pend && !ack_now && m_drops < (1 << DW) - 1) m_drops++;
            m_pend = 1;
         end else if (ack_now) begin
            m_pend = 0;
         end
         if (cyc >= settle_lo && cyc <= settle_hi && !vb && !late_done) begin
            late_done = 1;
            late_q.push_back(cyc + 1);
         end
         if (vs) begin
            m_frames = (m_frames + 1) % (1 << FW);
            if (cyc >= idle_from) begin
               arb_at = cyc + 1; arb_elig = (m_div == 0);
               busy_lo = cyc + 1; busy_hi = cyc + 1; late_done = 0; idle_from = BIG;
            end
            m_div = (m_div + 1) % DIV;
         end
         if (done_at >= 0 && cyc >= done_at && !vb) begin
            idle_from = cyc + 1; done_at = -1;
         end
      end
   endtask

   task automatic idle(input int n, input int spi_pct, input logic dr);
      for (int i = 0; i < n; i++)
         step(1'b0, 1'b0, 1'b0, ($urandom_range(99) < spi_pct), dr);
   endtask

   task automatic frame(input int vlen, input int spi_pct, input logic dr, input bit extra_vs);
      for (int i = 0; i < vlen; i++)
         step(1'b0, (i == 0) || (extra_vs && i == 2), 1'b1, ($urandom_range(99) < spi_pct), dr);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            check("missed_strobe", 32'h0, {30'h0, sb_q[0].kind});
            void'(sb_q.pop_front());
         end
         if (o_load_spi || o_load_demo || o_spi_ack) begin
            if (sb_q.size() == 0 || sb_q[0].cyc != cyc) begin
               check("unexpected_strobe", {29'h0, o_spi_ack, o_load_demo, o_load_spi}, 32'h0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("strobe_kind", {30'h0, o_load_demo, o_load_spi}, {30'h0, e.kind});
               check("spi_ack", {31'h0, o_spi_ack}, {31'h0, e.kind == 2'b01});
            end
         end
         while (late_q.size() > 0 && late_q[0] < cyc) begin
            check("missed_late", 32'h0, 32'h1);
            void'(late_q.pop_front());
         end
         if (o_late) begin
            if (late_q.size() == 0 || late_q[0] != cyc) check("unexpected_late", 32'h1, 32'h0);
            else begin
               check("late", {31'h0, o_late}, 32'h1);
               void'(late_q.pop_front());
            end
         end
         check("busy", {31'h0, o_busy}, {31'h0, exp_busy});
         check("grant", {30'h0, o_grant}, {30'h0, exp_grant});
         check("frame_count", {{(32-FW){1'b0}}, o_frame_count}, {{(32-FW){1'b0}}, exp_frames});
         check("drop_count", {{(32-DW){1'b0}}, o_drop_count}, {{(32-DW){1'b0}}, exp_drops});
      end
   end

   initial begin
      step(1'b1, 0, 0, 0, 0);
      step(1'b1, 0, 0, 0, 0);
      chk_en = 1'b1;
      // single spi frame: strobe two cycles after vsync, grant spi
      idle(2, 0, 1'b0);
      step(1'b0, 0, 0, 1, 0);
      idle(1, 0, 1'b0);
      frame(10, 0, 1'b0, 0);
      idle(3, 0, 1'b0);
      // spi and demo competing over several frames with new spi data each frame
      for (int f = 0; f < 4; f++) begin
         step(1'b0, 0, 0, 1, 1);
         idle(2, 0, 1'b1);
         frame(9, 0, 1'b1, 0);
      end
      // drops: three arrivals, then a burst that saturates the counter
      idle(2, 0, 1'b0);
      for (int i = 0; i < 3; i++) begin step(1'b0, 0, 0, 1, 0); idle(1, 0, 1'b0); end
      frame(8, 0, 1'b0, 0);
      idle(2, 0, 1'b0);
      for (int i = 0; i < 10; i++) begin step(1'b0, 0, 0, 1, 0); idle(1, 0, 1'b0); end
      // vblank ending inside SETTLE
      frame(3, 0, 1'b0, 0);
      idle(8, 0, 1'b0);
      // reset held across the ARB and LOAD cycles: no strobe, grant back to none
      step(1'b0, 0, 0, 1, 0);
      idle(1, 0, 1'b0);
      step(1'b0, 1, 1, 0, 0);
      step(1'b1, 0, 1, 0, 0);
      step(1'b1, 0, 1, 0, 0);
      frame(6, 0, 1'b0, 0);
      idle(3, 0, 1'b0);
      // randomized frames, including short vblanks and ignored mid-frame vsyncs
      for (int f = 0; f < 80; f++) begin
         logic dr;
         dr = 1'($urandom_range(1));
         idle($urandom_range(10, 2), 20, dr);
         frame($urandom_range(S + 8, 2), 15, dr, ($urandom_range(4) == 0));
      end
      idle(12, 0, 1'b0);
      n_checks++;
      if (sb_q.size() != 0 || late_q.size() != 0) begin
         n_errors++;
         $display("FAIL leftover_expectations: strobes %0d late %0d expected 0 0", sb_q.size(), late_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
